rs_encoder_ctrl: RTL and testbench

Sequencer for the parallel RS(68,64) parity encoder. It accepts a byte stream with valid/ready and buffers 64 bytes into the encoder's parallel message port. It fires the encoder once, captures the 4 parity bytes, and emits a systematic 68-byte codeword stream: 64 message bytes, then 4 parity bytes. It sits between the upstream byte source and the framing/serializer logic. The encoder itself is instantiated beside it.

---
 rtl/rs_encoder_ctrl_if.sv | 31 +++
 rtl/rs_encoder_ctrl.sv | 145 ++++++++++++++
 tb/tb_rs_encoder_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_encoder_ctrl_if.sv
// Byte-stream, encoder-port and error signals around the RS(68,64) sequencer.
// master = controller side, slave = surrounding source/sink/encoder side.
interface rs_encoder_ctrl_if #(
   parameter int unsigned K    = 64,
   parameter int unsigned NPAR = 4
) ();
   logic [7:0]           s_data;
   logic                 s_valid;
   logic                 s_ready;
   logic [7:0]           m_data;
   logic                 m_valid;
   logic                 m_ready;
   logic                 m_first;
   logic                 m_last;
   logic [K-1:0][7:0]    enc_msg;
   logic                 enc_msg_valid;
   logic [NPAR-1:0][7:0] enc_parity;
   logic                 enc_parity_valid;
   logic                 err_timeout;
   logic                 err_clr;

   modport master (
      input  s_data, s_valid, m_ready, enc_parity, enc_parity_valid, err_clr,
      output s_ready, m_data, m_valid, m_first, m_last, enc_msg, enc_msg_valid, err_timeout
   );

   modport slave (
      output s_data, s_valid, m_ready, enc_parity, enc_parity_valid, err_clr,
      input  s_ready, m_data, m_valid, m_first, m_last, enc_msg, enc_msg_valid, err_timeout
   );
endinterface

// File: rtl/rs_encoder_ctrl.sv
// Sequencer for a parallel RS(68,64) encoder: buffers 64 message bytes, fires the
// encoder once and streams a systematic 68-byte codeword (message, then parity).
module rs_encoder_ctrl #(
   parameter int unsigned PAR_TIMEOUT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   rs_encoder_ctrl_if.master bus
);
   localparam int unsigned K      = 64;
   localparam int unsigned NPAR   = 4;
   localparam int unsigned CNT_W  = 6;
   localparam int unsigned IDX_W  = 2;
   localparam int unsigned WAIT_W = 4;

   localparam logic [1:0] ST_COLLECT = 2'd0;
   localparam logic [1:0] ST_LAUNCH  = 2'd1;
   localparam logic [1:0] ST_WAIT    = 2'd2;
   localparam logic [1:0] ST_PARITY  = 2'd3;

   logic [1:0]           state, state_nxt;
   logic                 active, active_nxt;
   logic [CNT_W-1:0]     byte_cnt, byte_cnt_nxt;
   logic [IDX_W-1:0]     par_idx, par_idx_nxt;
   logic [WAIT_W-1:0]    wait_cnt, wait_cnt_nxt, wait_inc;
   logic [K-1:0][7:0]    msg_buf, msg_buf_nxt;
   logic [NPAR-1:0][7:0] par_reg, par_reg_nxt;
   logic [7:0]           m_data_q, m_data_nxt;
   logic                 m_valid_q, m_valid_nxt;
   logic                 m_first_q, m_first_nxt;
   logic                 m_last_q, m_last_nxt;
   logic                 launch_q, launch_nxt;
   logic                 err_q, err_nxt;
   logic                 load_ok, s_ready_c;

   // Next-state and next-register values; output stage is a single skid-free register.
   always_comb begin
      state_nxt    = state;
      active_nxt   = 1'b1;
      byte_cnt_nxt = byte_cnt;
      par_idx_nxt  = par_idx;
      wait_cnt_nxt = wait_cnt;
      msg_buf_nxt  = msg_buf;
      par_reg_nxt  = par_reg;
      m_data_nxt   = m_data_q;
      m_valid_nxt  = m_valid_q;
      m_first_nxt  = m_first_q;
      m_last_nxt   = m_last_q;
      launch_nxt   = 1'b0;
      err_nxt      = err_q;
      wait_inc     = wait_cnt + WAIT_W'(1);
      load_ok      = !m_valid_q || bus.m_ready;
      s_ready_c    = active && (state == ST_COLLECT) && load_ok;

      if (bus.err_clr) err_nxt = 1'b0;
      if (m_valid_q && bus.m_ready) m_valid_nxt = 1'b0;

      case (state)
         ST_COLLECT: begin
            if (bus.s_valid && s_ready_c) begin
               msg_buf_nxt[byte_cnt] = bus.s_data;
               m_data_nxt   = bus.s_data;
               m_valid_nxt  = 1'b1;
               m_first_nxt  = (byte_cnt == '0);
               m_last_nxt   = 1'b0;
               byte_cnt_nxt = byte_cnt + CNT_W'(1);
               if (byte_cnt == CNT_W'(K - 1)) begin
                  launch_nxt = 1'b1;
                  state_nxt  = ST_LAUNCH;
               end
            end
         end
         ST_LAUNCH: begin
            wait_cnt_nxt = '0;
            state_nxt    = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.enc_parity_valid) begin
               par_reg_nxt = bus.enc_parity;
               state_nxt   = ST_PARITY;
            end else if (wait_inc == WAIT_W'(PAR_TIMEOUT)) begin
               // Unresponsive encoder: flag it but still emit zero parity to keep framing.
               err_nxt      = 1'b1;
               par_reg_nxt  = '0;
               wait_cnt_nxt = '0;
               state_nxt    = ST_PARITY;
            end else begin
               wait_cnt_nxt = wait_inc;
            end
         end
         ST_PARITY: begin
            if (load_ok) begin
               m_data_nxt  = par_reg[par_idx];
               m_valid_nxt = 1'b1;
               m_first_nxt = 1'b0;
               m_last_nxt  = (par_idx == IDX_W'(NPAR - 1));
               par_idx_nxt = par_idx + IDX_W'(1);
               if (par_idx == IDX_W'(NPAR - 1)) state_nxt = ST_COLLECT;
            end
         end
         default: state_nxt = ST_COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_COLLECT;
         active    <= 1'b0;
         byte_cnt  <= '0;
         par_idx   <= '0;
         wait_cnt  <= '0;
         msg_buf   <= '0;
         par_reg   <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         m_first_q <= 1'b0;
         m_last_q  <= 1'b0;
         launch_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state     <= state_nxt;
         active    <= active_nxt;
         byte_cnt  <= byte_cnt_nxt;
         par_idx   <= par_idx_nxt;
         wait_cnt  <= wait_cnt_nxt;
         msg_buf   <= msg_buf_nxt;
         par_reg   <= par_reg_nxt;
         m_data_q  <= m_data_nxt;
         m_valid_q <= m_valid_nxt;
         m_first_q <= m_first_nxt;
         m_last_q  <= m_last_nxt;
         launch_q  <= launch_nxt;
         err_q     <= err_nxt;
      end
   end

   assign bus.s_ready       = s_ready_c;
   assign bus.m_data        = m_data_q;
   assign bus.m_valid       = m_valid_q;
   assign bus.m_first       = m_first_q;
   assign bus.m_last        = m_last_q;
   assign bus.enc_msg       = msg_buf;
   assign bus.enc_msg_valid = launch_q;
   assign bus.err_timeout   = err_q;
endmodule

// File: tb/tb_rs_encoder_ctrl.sv
// Directed bench for rs_encoder_ctrl with a behavioural RS(68,64) encoder beside it.
// Parity bytes are emitted highest-degree remainder coefficient first.
module tb_rs_encoder_ctrl;
   localparam int K      = 64;
   localparam int NPAR   = 4;
   localparam int BUDGET = 20000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   bit   stub_en  = 1'b1;

   logic [7:0] tx_q[$];
   logic [9:0] exp_q[$];
   logic [9:0] obs_q[$];
   int stall_err, launch_cnt, launch_cyc, first_out_cyc, first_acc_cyc;
   int acc64_cyc, err_rise_cyc, ready_low;

   rs_encoder_ctrl_if bus ();
   rs_encoder_ctrl #(.PAR_TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
      end
      return p;
   endfunction

   // g(x) = prod_{i=0..3} (x + alpha^i); systematic remainder via LFSR division.
   function automatic logic [NPAR-1:0][7:0] rs_parity(input logic [K-1:0][7:0] msg);
      logic [7:0] g [NPAR+1];
      logic [7:0] rem [NPAR];
      logic [7:0] r, fb;
      logic [NPAR-1:0][7:0] p;
      for (int j = 0; j <= NPAR; j++) g[j] = 8'h00;
      g[0] = 8'h01;
      r    = 8'h01;
      for (int i = 0; i < NPAR; i++) begin
         for (int j = i + 1; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], r);
         g[0] = gf_mul(g[0], r);
         r    = gf_mul(r, 8'h02);
      end
      for (int j = 0; j < NPAR; j++) rem[j] = 8'h00;
      for (int i = 0; i < K; i++) begin
         fb = msg[i] ^ rem[NPAR-1];
         for (int j = NPAR - 1; j > 0; j--) rem[j] = rem[j-1] ^ gf_mul(fb, g[j]);
         rem[0] = gf_mul(fb, g[0]);
      end
      for (int j = 0; j < NPAR; j++) p[j] = rem[NPAR-1-j];
      return p;
   endfunction

   // Encoder stub: one-cycle latency from msg_valid to parity_valid.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.enc_parity_valid <= 1'b0;
         bus.enc_parity       <= '0;
      end else begin
         bus.enc_parity_valid <= stub_en && bus.enc_msg_valid;
         if (bus.enc_msg_valid) bus.enc_parity <= rs_parity(bus.enc_msg);
      end
   end

   task automatic add_codeword(input logic [K-1:0][7:0] msg, input bit zero_par);
      logic [NPAR-1:0][7:0] p;
      p = zero_par ? '0 : rs_parity(msg);
      for (int i = 0; i < K; i++) begin
         tx_q.push_back(msg[i]);
         exp_q.push_back({(i == 0), 1'b0, msg[i]});
      end
      for (int i = 0; i < NPAR; i++) exp_q.push_back({1'b0, (i == NPAR - 1), p[i]});
   endtask

   // Drives tx_q, randomises m_ready and records observed outputs/events per cycle.
   task automatic run_stream(input int unsigned sv_pct, input int unsigned mr_pct, input int max_acc);
      int idx = 0;
      int used = 0;
      bit stall_prev = 1'b0;
      bit err_prev = 1'b0;
      logic [9:0] stall_val = '0;
      logic [9:0] cur;
      stall_err = 0; launch_cnt = 0; launch_cyc = -1; first_out_cyc = -1;
      first_acc_cyc = -1; acc64_cyc = -1; err_rise_cyc = -1; ready_low = 0;
      obs_q.delete();
      while (((idx < max_acc) || (obs_q.size() < exp_q.size())) && (used < BUDGET)) begin
         @(posedge clk); #1;
         bus.s_valid = (idx < max_acc) && ($urandom_range(99) < sv_pct);
         if (idx < max_acc) bus.s_data = tx_q[idx];
         bus.m_ready = ($urandom_range(99) < mr_pct);
         @(negedge clk);
         if (bus.s_valid && bus.s_ready) begin
            if (idx == 0) first_acc_cyc = cyc;
            if (idx == K - 1) acc64_cyc = cyc;
            idx++;
         end else if (bus.s_valid) begin
            ready_low++;
         end
         cur = {bus.m_first, bus.m_last, bus.m_data};
         if (stall_prev && (!bus.m_valid || (cur !== stall_val))) stall_err++;
         stall_prev = bus.m_valid && !bus.m_ready;
         stall_val  = cur;
         if (bus.m_valid && bus.m_ready) begin
            if (obs_q.size() == 0) first_out_cyc = cyc;
            obs_q.push_back(cur);
         end
         if (bus.enc_msg_valid) begin
            launch_cnt++;
            launch_cyc = cyc;
         end
         if (bus.err_timeout && !err_prev) err_rise_cyc = cyc;
         err_prev = bus.err_timeout;
         used++;
      end
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
      bus.m_ready = 1'b1;
   endtask

   task automatic test_reset();
      logic [K-1:0][7:0] zero_msg = '0;
      bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.m_ready = 1'b1; bus.err_clr = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready got=%b exp=0", bus.s_ready); end
      checks++;
      if ({bus.m_valid, bus.m_first, bus.m_last, bus.enc_msg_valid, bus.err_timeout} !== 5'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=00000",
                  {bus.m_valid, bus.m_first, bus.m_last, bus.enc_msg_valid, bus.err_timeout});
      end
      checks++;
      if (bus.m_data !== 8'h00) begin failures++; $display("FAIL reset_m_data got=%h exp=00", bus.m_data); end
      checks++;
      if (bus.enc_msg !== zero_msg) begin failures++; $display("FAIL reset_enc_msg got=%h exp=0", bus.enc_msg); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL s_ready_after_reset got=%b exp=1", bus.s_ready); end
   endtask

   task automatic test_single();
      logic [K-1:0][7:0] m;
      logic [9:0] got;
      for (int i = 0; i < K; i++) m[i] = 8'(i);
      tx_q.delete(); exp_q.delete();
      add_codeword(m, 1'b0);
      run_stream(100, 100, K);
      checks++;
      if (obs_q.size() != 68) begin failures++; $display("FAIL single_count got=%0d exp=68", obs_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < obs_q.size()) ? obs_q[i] : 'x;
         checks++;
         if (got !== exp_q[i]) begin failures++; $display("FAIL single_byte[%0d] got=%h exp=%h", i, got, exp_q[i]); end
      end
      checks++;
      if (launch_cnt != 1) begin failures++; $display("FAIL single_launch_count got=%0d exp=1", launch_cnt); end
      checks++;
      if (launch_cyc != acc64_cyc + 1) begin
         failures++; $display("FAIL single_launch_cycle got=%0d exp=%0d", launch_cyc, acc64_cyc + 1);
      end
      checks++;
      if (first_out_cyc != first_acc_cyc + 1) begin
         failures++; $display("FAIL single_latency got=%0d exp=%0d", first_out_cyc, first_acc_cyc + 1);
      end
      checks++;
      if (bus.err_timeout !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", bus.err_timeout); end
   endtask

   task automatic test_all_zero();
      logic [9:0] got;
      tx_q.delete(); exp_q.delete();
      add_codeword('0, 1'b1);
      run_stream(100, 100, K);
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < obs_q.size()) ? obs_q[i] : 'x;
         checks++;
         if (got !== exp_q[i]) begin failures++; $display("FAIL zero_byte[%0d] got=%h exp=%h", i, got, exp_q[i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [K-1:0][7:0] m;
      logic [9:0] got;
      tx_q.delete(); exp_q.delete();
      for (int c = 0; c < 2; c++) begin
         for (int i = 0; i < K; i++) m[i] = 8'(8'hA5 ^ (i * (c + 3)));
         add_codeword(m, 1'b0);
      end
      run_stream(100, 100, 2 * K);
      checks++;
      if (obs_q.size() != 136) begin failures++; $display("FAIL b2b_count got=%0d exp=136", obs_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < obs_q.size()) ? obs_q[i] : 'x;
         checks++;
         if (got !== exp_q[i]) begin failures++; $display("FAIL b2b_byte[%0d] got=%h exp=%h", i, got, exp_q[i]); end
      end
      checks++;
      if (ready_low != 6) begin failures++; $display("FAIL b2b_ready_low got=%0d exp=6", ready_low); end
   endtask

   task automatic test_backpressure();
      logic [K-1:0][7:0] m;
      logic [9:0] got;
      tx_q.delete(); exp_q.delete();
      for (int c = 0; c < 10; c++) begin
         for (int i = 0; i < K; i++) m[i] = 8'($urandom);
         add_codeword(m, 1'b0);
      end
      run_stream(60, 50, 10 * K);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++; $display("FAIL bp_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < obs_q.size()) ? obs_q[i] : 'x;
         checks++;
         if (got !== exp_q[i]) begin failures++; $display("FAIL bp_byte[%0d] got=%h exp=%h", i, got, exp_q[i]); end
      end
      checks++;
      if (stall_err != 0) begin failures++; $display("FAIL bp_stall_changes got=%0d exp=0", stall_err); end
      checks++;
      if (launch_cnt != 10) begin failures++; $display("FAIL bp_launches got=%0d exp=10", launch_cnt); end
   endtask

   task automatic test_timeout();
      logic [K-1:0][7:0] m;
      logic [9:0] got;
      for (int i = 0; i < K; i++) m[i] = 8'(3 * i + 1);
      stub_en = 1'b0;
      tx_q.delete(); exp_q.delete();
      add_codeword(m, 1'b1);
      run_stream(100, 100, K);
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < obs_q.size()) ? obs_q[i] : 'x;
         checks++;
         if (got !== exp_q[i]) begin failures++; $display("FAIL to_byte[%0d] got=%h exp=%h", i, got, exp_q[i]); end
      end
      checks++;
      if (err_rise_cyc != acc64_cyc + 6) begin
         failures++; $display("FAIL to_err_cycle got=%0d exp=%0d", err_rise_cyc, acc64_cyc + 6);
      end
      @(negedge clk);
      checks++;
      if (bus.err_timeout !== 1'b1) begin failures++; $display("FAIL to_err_sticky got=%b exp=1", bus.err_timeout); end
      @(posedge clk); #1;
      bus.err_clr = 1'b1;
      @(posedge clk); #1;
      bus.err_clr = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.err_timeout !== 1'b0) begin failures++; $display("FAIL to_err_clear got=%b exp=0", bus.err_timeout); end
      stub_en = 1'b1;
   endtask

   task automatic test_mid_reset();
      logic [K-1:0][7:0] m;
      logic [K-1:0][7:0] zero_msg = '0;
      logic [9:0] got;
      for (int i = 0; i < K; i++) m[i] = 8'(8'hF0 - i);
      tx_q.delete(); exp_q.delete();
      for (int i = 0; i < K; i++) tx_q.push_back(m[i]);
      run_stream(100, 100, 30);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.s_ready, bus.m_valid, bus.m_first, bus.m_last, bus.enc_msg_valid} !== 5'b0) begin
         failures++;
         $display("FAIL midrst_flags got=%b exp=00000",
                  {bus.s_ready, bus.m_valid, bus.m_first, bus.m_last, bus.enc_msg_valid});
      end
      checks++;
      if (bus.m_data !== 8'h00) begin failures++; $display("FAIL midrst_m_data got=%h exp=00", bus.m_data); end
      checks++;
      if (bus.enc_msg !== zero_msg) begin failures++; $display("FAIL midrst_enc_msg got=%h exp=0", bus.enc_msg); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < K; i++) m[i] = 8'(5 * i + 7);
      tx_q.delete(); exp_q.delete();
      add_codeword(m, 1'b0);
      run_stream(100, 100, K);
      checks++;
      if (obs_q.size() != 68) begin failures++; $display("FAIL midrst_count got=%0d exp=68", obs_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < obs_q.size()) ? obs_q[i] : 'x;
         checks++;
         if (got !== exp_q[i]) begin failures++; $display("FAIL midrst_byte[%0d] got=%h exp=%h", i, got, exp_q[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_zero();
      test_back_to_back();
      test_backpressure();
      test_timeout();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
